// File: rtl/relay_rx_frontend_pkg.sv
// Shared definitions for the relay receive front-end: idle line level,
// FSM state encoding and a saturating counter helper.
package relay_rx_frontend_pkg;

  // The encoder and decoder agree on this level for an idle line.
  localparam logic RELAY_IDLE_LEVEL = 1'b0;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } rx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hff) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/relay_rx_frontend_sync.sv
// Generic multi-flop synchroniser for an asynchronous single-bit input.
// The chain resets to the idle line level so no edge is seen at reset release.
module relay_sync #(
  parameter int   STAGES     = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // active-low reset so every flop lands at a defined value without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= {STAGES{IDLE_LEVEL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/relay_rx_frontend.sv
// Relay pin conditioning: synchronise, reject short glitches, track activity
// and flag start-of-frame for the downstream relay decoder.
module relay_rx_frontend
  import relay_rx_frontend_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FILTER_LEN   = 4,
  parameter int unsigned IDLE_TIMEOUT = 1024,
  parameter logic        IDLE_LEVEL   = RELAY_IDLE_LEVEL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       relay_in,
  output logic       data_out,
  output logic       edge_pulse,
  output logic       sof,
  output logic       line_idle,
  output logic [7:0] glitch_cnt
);

  localparam logic [3:0]  STAB_LAST = 4'(FILTER_LEN - 1);
  localparam logic [15:0] IDLE_LAST = 16'(IDLE_TIMEOUT - 1);
  localparam logic [15:0] IDLE_MAX  = 16'(IDLE_TIMEOUT);

  logic       s;
  logic [3:0] stab_cnt;
  logic [15:0] idle_cnt;
  rx_state_e  state;

  logic s_diff;
  logic flip;
  logic glitch;

  relay_sync #(
    .STAGES     (SYNC_STAGES),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (relay_in),
    .q     (s)
  );

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    s_diff = 1'b0;
    flip   = 1'b0;
    glitch = 1'b0;
    if (enable) begin
      s_diff = (s != data_out);
      flip   = s_diff && (stab_cnt == STAB_LAST);
      glitch = !s_diff && (stab_cnt != 4'd0);
    end
  end

  // Filter and idle counter; a flip is the only way data_out follows s.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= IDLE_LEVEL;
      edge_pulse <= 1'b0;
      stab_cnt   <= '0;
      idle_cnt   <= '0;
      glitch_cnt <= '0;
    end else if (!enable) begin
      // Forced idle: the level is dropped silently, glitch history is kept.
      data_out   <= IDLE_LEVEL;
      edge_pulse <= 1'b0;
      stab_cnt   <= '0;
      idle_cnt   <= '0;
    end else begin
      edge_pulse <= flip;
      if (flip) begin
        data_out <= s;
        stab_cnt <= '0;
        idle_cnt <= '0;
      end else begin
        stab_cnt <= s_diff ? stab_cnt + 4'd1 : 4'd0;
        if (idle_cnt != IDLE_MAX) begin
          idle_cnt <= idle_cnt + 16'd1;
        end
      end
      if (glitch) begin
        glitch_cnt <= sat_inc8(glitch_cnt);
      end
    end
  end

  // Activity FSM; line_idle is registered alongside the state it mirrors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      line_idle <= 1'b1;
      sof       <= 1'b0;
    end else if (!enable) begin
      state     <= S_IDLE;
      line_idle <= 1'b1;
      sof       <= 1'b0;
    end else begin
      sof <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flip) begin
            state     <= S_ACTIVE;
            line_idle <= 1'b0;
            sof       <= 1'b1;
          end
        end
        S_ACTIVE: begin
          // An edge landing in the timeout cycle keeps the frame alive.
          if (!flip && idle_cnt == IDLE_LAST) begin
            state     <= S_IDLE;
            line_idle <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          line_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relay_rx_frontend.sv
// Scoreboard bench for relay_rx_frontend: stimulus queues expected edge and
// idle events with their cycle numbers, a monitor matches them as they appear.
module tb_relay_rx_frontend;

  localparam int SYNC_STAGES  = 2;
  localparam int FILTER_LEN   = 4;
  localparam int IDLE_TIMEOUT = 16;
  localparam int LAT          = SYNC_STAGES + FILTER_LEN;

  typedef struct {
    int cyc;
    bit is_pulse;
    bit level;
    bit sof;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       relay_in;
  logic       data_out;
  logic       edge_pulse;
  logic       sof;
  logic       line_idle;
  logic [7:0] glitch_cnt;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_on = 1'b0;
  bit   prev_idle = 1'b1;

  relay_rx_frontend #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_LEN   (FILTER_LEN),
    .IDLE_TIMEOUT (IDLE_TIMEOUT),
    .IDLE_LEVEL   (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .relay_in   (relay_in),
    .data_out   (data_out),
    .edge_pulse (edge_pulse),
    .sof        (sof),
    .line_idle  (line_idle),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pin(input logic v, input bit expect_edge, input bit exp_sof);
    relay_in = v;
    if (expect_edge) exp_q.push_back('{cyc + LAT, 1'b1, v, exp_sof});
  endtask

  task automatic push_idle(input int at);
    exp_q.push_back('{at, 1'b0, 1'b0, 1'b0});
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (mon_on) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missed_event_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (sof && !edge_pulse) check("sof_without_edge", sof, 1'b0);
      if (edge_pulse || (line_idle && !prev_idle)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", edge_pulse, 1'b0);
          check("unexpected_idle_rise", line_idle && !prev_idle, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("event_is_pulse", edge_pulse, e.is_pulse);
          if (e.is_pulse) begin
            check("edge_level", data_out, e.level);
            check("edge_sof", sof, e.sof);
          end
        end
      end
    end
    prev_idle = line_idle;
  end

  initial begin
    int m;
    int b;
    logic v;

    reset    = 1'b0;
    enable   = 1'b1;
    relay_in = 1'b0;
    tick(2);
    check("rst_data_out", data_out, 1'b0);
    check("rst_edge_pulse", edge_pulse, 1'b0);
    check("rst_sof", sof, 1'b0);
    check("rst_line_idle", line_idle, 1'b1);
    check("rst_glitch_cnt", glitch_cnt, 8'd0);
    reset  = 1'b1;
    mon_on = 1'b1;
    tick(2);

    // 1: clean rising edge, then the line times out on its own.
    set_pin(1'b1, 1'b1, 1'b1);
    push_idle(cyc + LAT + IDLE_TIMEOUT);
    tick(20);
    check("t1_data_out", data_out, 1'b1);
    check("t1_line_idle", line_idle, 1'b0);

    // 2: 3-cycle low glitches are rejected and counted, saturating at 255.
    relay_in = 1'b0; tick(3);
    relay_in = 1'b1; tick(8);
    check("t2_glitch_one", glitch_cnt, 8'd1);
    check("t2_data_out", data_out, 1'b1);
    for (int i = 0; i < 299; i++) begin
      relay_in = 1'b0; tick(3);
      relay_in = 1'b1; tick(5);
    end
    check("t2_glitch_sat", glitch_cnt, 8'd255);
    check("t2_data_out_held", data_out, 1'b1);
    check("t2_line_idle", line_idle, 1'b1);

    // 3: toggle every 8 cycles; only the first edge carries sof.
    v = 1'b0;
    for (int i = 0; i < 11; i++) begin
      set_pin(v, 1'b1, i == 0);
      v = ~v;
      tick(8);
    end
    check("t3_line_idle", line_idle, 1'b0);

    // Edge landing exactly in the timeout cycle keeps the frame active.
    tick(8);
    set_pin(1'b1, 1'b1, 1'b0);
    b = cyc;
    push_idle(b + LAT + IDLE_TIMEOUT);

    // 4: line goes idle 16 cycles after the last edge; next edge gives sof.
    tick(30);
    check("t4_idle", line_idle, 1'b1);
    check("t4_data_out", data_out, 1'b1);
    set_pin(1'b0, 1'b1, 1'b1);
    push_idle(cyc + LAT + IDLE_TIMEOUT);
    tick(30);
    check("t4_idle_again", line_idle, 1'b1);
    check("t4_data_out_low", data_out, 1'b0);

    // 5: disable mid-filter (stab_cnt == 2), then re-enable with pin high.
    set_pin(1'b1, 1'b0, 1'b0);
    tick(4);
    enable = 1'b0;
    tick(10);
    check("t5_disabled_data_out", data_out, 1'b0);
    check("t5_disabled_idle", line_idle, 1'b1);
    enable = 1'b1;
    m = cyc;
    exp_q.push_back('{m + FILTER_LEN, 1'b1, 1'b1, 1'b1});
    tick(10);
    check("t5_reenabled_data_out", data_out, 1'b1);
    check("t5_reenabled_idle", line_idle, 1'b0);
    check("t5_glitch_held", glitch_cnt, 8'd255);

    // 6: asynchronous reset between clock edges while the line is active.
    mon_on = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("t6_data_out", data_out, 1'b0);
    check("t6_edge_pulse", edge_pulse, 1'b0);
    check("t6_sof", sof, 1'b0);
    check("t6_line_idle", line_idle, 1'b1);
    check("t6_glitch_cnt", glitch_cnt, 8'd0);
    tick(2);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
